rs232_echo_fifo: RTL and testbench



---
 rtl/rs232_echo_fifo_if.sv | 20 ++
 rtl/rs232_echo_fifo.sv | 141 ++++++++++++++
 tb/tb_rs232_echo_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_echo_fifo_if.sv
// Avalon-MM bus between the echo master and the UART core's slave port.
// Handshake: a transfer completes in any cycle where (avm_read | avm_write) = 1 and avm_waitrequest = 0; while avm_waitrequest = 1 the master holds address, strobes and writedata.
interface rs232_echo_fifo_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/rs232_echo_fifo.sv
// Polls the UART status, buffers RX characters in a circular FIFO and echoes them to TX.
// Optional RS232_UPPERCASE_EN: 8-bit lowercase ASCII is folded to uppercase on push.
module rs232_echo_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int RX_OK_BIT = 7,
    parameter int TX_OK_BIT = 6
) (
    input  logic                     avm_clk,
    input  logic                     avm_rst,
    rs232_echo_fifo_if.master        avm,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              tx_count,
    output logic [1:0]               o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    typedef enum logic [1:0] {
        S_STATUS = 2'd0,
        S_RX     = 2'd1,
        S_TX     = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_op;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [15:0]         r_tx_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [4:0]          r_address;
    logic                r_read;
    logic                r_write;
    logic [31:0]         r_writedata;

    logic                w_done;
    logic                w_full;
    logic                w_empty;
    logic                w_rx_ok;
    logic                w_tx_ok;
    logic                w_pick_tx;
    logic                w_push;
    logic [DATA_W-1:0]   w_rx_char;
    logic [DATA_W-1:0]   w_head;
    logic                w_unused_rd;

    function automatic logic [DATA_W-1:0] f_conv(input logic [DATA_W-1:0] d);
`ifdef RS232_UPPERCASE_EN
        logic [7:0] e;
        e = 8'(d);
        if (DATA_W == 8 && e >= 8'h61 && e <= 8'h7A)
            return DATA_W'(e - 8'h20);
        return d;
`else
        return d;
`endif
    endfunction

    assign w_done      = (r_read | r_write) && !avm.avm_waitrequest;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_rx_ok     = avm.avm_readdata[RX_OK_BIT] && !w_full;
    assign w_tx_ok     = avm.avm_readdata[TX_OK_BIT] && !w_empty;
    // When both sides are ready, serve the one not served last time.
    assign w_pick_tx   = w_tx_ok && (!w_rx_ok || !r_last_op);
    assign w_push      = !avm_rst && w_done && (r_state == S_RX);
    assign w_rx_char   = f_conv(avm.avm_readdata[DATA_W-1:0]);
    assign w_head      = r_mem[r_rptr];
    assign w_unused_rd = ^avm.avm_readdata;

    // Storage is not reset; flushing only clears the pointers and count.
    always_ff @(posedge avm_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_rx_char;
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_state     <= S_STATUS;
            r_last_op   <= 1'b1;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_tx_count  <= '0;
            r_address   <= ADDR_STATUS;
            r_read      <= 1'b1;
            r_write     <= 1'b0;
            r_writedata <= '0;
        end else if (w_done) begin
            case (r_state)
                S_STATUS: begin
                    if (w_pick_tx) begin
                        r_state     <= S_TX;
                        r_address   <= ADDR_TX;
                        r_read      <= 1'b0;
                        r_write     <= 1'b1;
                        r_writedata <= {{(32-DATA_W){1'b0}}, w_head};
                    end else if (w_rx_ok) begin
                        r_state   <= S_RX;
                        r_address <= ADDR_RX;
                    end
                end
                S_RX: begin
                    r_wptr    <= r_wptr + 1'b1;
                    r_count   <= r_count + 1'b1;
                    r_last_op <= 1'b0;
                    r_state   <= S_STATUS;
                    r_address <= ADDR_STATUS;
                end
                S_TX: begin
                    r_rptr     <= r_rptr + 1'b1;
                    r_count    <= r_count - 1'b1;
                    r_tx_count <= r_tx_count + 16'd1;
                    r_last_op  <= 1'b1;
                    r_state    <= S_STATUS;
                    r_address  <= ADDR_STATUS;
                    r_read     <= 1'b1;
                    r_write    <= 1'b0;
                end
                default: begin
                    r_state   <= S_STATUS;
                    r_address <= ADDR_STATUS;
                    r_read    <= 1'b1;
                    r_write   <= 1'b0;
                end
            endcase
        end
    end

    assign avm.avm_address   = r_address;
    assign avm.avm_read      = r_read;
    assign avm.avm_write     = r_write;
    assign avm.avm_writedata = r_writedata;
    assign fifo_count        = r_count;
    assign tx_count          = r_tx_count;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_rs232_echo_fifo.sv
// Bench for rs232_echo_fifo: a reactive UART slave model plus table-driven echo vectors.
module tb_rs232_echo_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  fifo_count;
    logic [15:0] tx_count;
    logic [1:0]  dbg_state;

    rs232_echo_fifo_if bus();

    rs232_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RX_OK_BIT(7), .TX_OK_BIT(6)) dut (
        .avm_clk     (clk),
        .avm_rst     (rst),
        .avm         (bus.master),
        .fifo_count  (fifo_count),
        .tx_count    (tx_count),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] op_log[$];
    logic       tx_ready;
    int         stall_left, stall_seen, rx_reads, tx_writes, cyc, last_tx_cyc;
    logic       stall_active;
    logic [4:0] hold_addr;
    logic [31:0] hold_wd;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] exp_up;
        logic [7:0] exp_raw;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave response for the current cycle; completions are logged here.
    task automatic respond();
        logic [7:0] exp_b;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;
        chk("no_read_and_write", {31'd0, bus.avm_read & bus.avm_write}, 32'd0);
        if (bus.avm_write && stall_left > 0) begin
            bus.avm_waitrequest = 1'b1;
            stall_left--;
            stall_seen++;
        end
        if (stall_active)
            chk("stall_hold", {bus.avm_write, 22'd0, bus.avm_address, bus.avm_writedata[7:0]},
                {1'b1, 22'd0, hold_addr, hold_wd[7:0]});
        if (bus.avm_write && bus.avm_waitrequest && !stall_active) begin
            stall_active = 1'b1;
            hold_addr = bus.avm_address;
            hold_wd = bus.avm_writedata;
        end
        if (bus.avm_read && bus.avm_address == 5'd8) begin
            bus.avm_readdata = {24'h0, (rx_q.size() != 0), tx_ready, 6'b0};
        end else if (bus.avm_read && bus.avm_address == 5'd0) begin
            bus.avm_readdata = {24'hA5A5A5, (rx_q.size() != 0) ? rx_q[0] : 8'h00};
            if (rx_q.size() == 0)
                chk("rx_read_when_empty", 32'd1, 32'd0);
            else begin
                void'(rx_q.pop_front());
                rx_reads++;
                op_log.push_back("R");
            end
        end else if (bus.avm_write && bus.avm_address == 5'd4) begin
            if (!bus.avm_waitrequest) begin
                stall_active = 1'b0;
                tx_writes++;
                last_tx_cyc = cyc + 1;
                op_log.push_back("T");
                chk("tx_when_ready", {31'd0, tx_ready}, 32'd1);
                if (exp_q.size() == 0)
                    chk("tx_unexpected", bus.avm_writedata, 32'hFFFFFFFF);
                else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_data", bus.avm_writedata, {24'h0, exp_b});
                end
            end
        end else if (bus.avm_read || bus.avm_write) begin
            chk("bad_address", {27'd0, bus.avm_address}, 32'd8);
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_left = 0;
        stall_seen = 0;
        stall_active = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_address", {27'd0, bus.avm_address}, 32'd8);
        chk("rst_strobes", {30'd0, bus.avm_read, bus.avm_write}, 32'd2);
        chk("rst_writedata", bus.avm_writedata, 32'd0);
        chk("rst_counts", {13'd0, fifo_count, tx_count}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        rx_reads = 0;
        tx_writes = 0;
        cyc = 0;
        last_tx_cyc = 0;
        op_log.delete();
        rst = 1'b0;
        respond();
    endtask

    task automatic wait_tx(input int n, input int bound, input string name);
        for (int k = 0; k < bound && tx_writes < n; k++) tick();
        chk(name, {31'd0, tx_writes >= n}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_v;
        logic [7:0] ops_full[8];
        vecs[0] = '{8'h41, 8'h41, 8'h41};
        vecs[1] = '{8'h61, 8'h41, 8'h61};
        vecs[2] = '{8'h7B, 8'h7B, 8'h7B};
        vecs[3] = '{8'h7A, 8'h5A, 8'h7A};
        vecs[4] = '{8'h60, 8'h60, 8'h60};
        vecs[5] = '{8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[7] = '{8'h5A, 8'h5A, 8'h5A};
        ops_full = '{"T", "R", "T", "R", "T", "T", "T", "T"};
        tx_ready = 1'b0;

        // Idle polling with nothing to do
        do_reset();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_poll", {25'd0, bus.avm_address, bus.avm_read, bus.avm_write}, {25'd0, 5'd8, 2'b10});
        end
        chk("idle_no_access", rx_reads + tx_writes, 32'd0);
        chk("idle_fifo", {29'd0, fifo_count}, 32'd0);

        // Back-to-back echo latency: status, RX, status, TX
        rx_q.push_back(8'h41);
        exp_q.push_back(8'h41);
        tx_ready = 1'b1;
        do_reset();
        wait_tx(1, 20, "echo_timeout");
        chk("echo_latency", last_tx_cyc, 32'd4);
        tick();
        chk("echo_tx_count", {16'd0, tx_count}, 32'd1);
        chk("echo_fifo", {29'd0, fifo_count}, 32'd0);

        // Table of single-character echoes
        tx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rx_q.push_back(vecs[i].rx);
            for (int k = 0; k < 20 && fifo_count != 3'd1; k++) tick();
            chk("vec_push", {29'd0, fifo_count}, 32'd1);
`ifdef RS232_UPPERCASE_EN
            exp_v = vecs[i].exp_up;
`else
            exp_v = vecs[i].exp_raw;
`endif
            exp_q.push_back(exp_v);
            tx_ready = 1'b1;
            wait_tx(i + 1, 20, "vec_timeout");
            tx_ready = 1'b0;
            tick();
            chk("vec_tx_count", {16'd0, tx_count}, i + 1);
            chk("vec_fifo", {29'd0, fifo_count}, 32'd0);
        end

        // Fill to full, then drain with arbitration and pointer wrap
        for (int c = 0; c < 6; c++) rx_q.push_back(8'h30 + 8'(c));
        tx_ready = 1'b0;
        do_reset();
        repeat (40) tick();
        chk("full_rx_reads", rx_reads, 32'd4);
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_rx_left", rx_q.size(), 32'd2);
        op_log.delete();
        for (int c = 0; c < 6; c++) exp_q.push_back(8'h30 + 8'(c));
        tx_ready = 1'b1;
        wait_tx(6, 80, "drain_timeout");
        for (int k = 0; k < 8; k++)
            chk("drain_order", {24'd0, (k < op_log.size()) ? op_log[k] : 8'h00}, {24'd0, ops_full[k]});
        tick();
        chk("drain_fifo", {29'd0, fifo_count}, 32'd0);
        chk("drain_tx_count", {16'd0, tx_count}, 32'd6);

        // Alternation from reset with both sides ready
        for (int c = 0; c < 4; c++) begin
            rx_q.push_back(8'h10 + 8'(c));
            exp_q.push_back(8'h10 + 8'(c));
        end
        tx_ready = 1'b1;
        do_reset();
        wait_tx(4, 40, "alt_timeout");
        for (int k = 0; k < 8; k++)
            chk("alt_order", {24'd0, (k < op_log.size()) ? op_log[k] : 8'h00},
                {24'd0, (k % 2 == 0) ? 8'h52 : 8'h54});

        // TX write stalled by waitrequest
        rx_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        tx_ready = 1'b1;
        do_reset();
        stall_left = 5;
        wait_tx(1, 30, "stall_timeout");
        repeat (5) tick();
        chk("stall_cycles", stall_seen, 32'd5);
        chk("stall_one_write", tx_writes, 32'd1);
        chk("stall_tx_count", {16'd0, tx_count}, 32'd1);
        chk("stall_fifo", {29'd0, fifo_count}, 32'd0);

        // Reset during a stalled TX write flushes the FIFO
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        tx_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("mid_fill", {29'd0, fifo_count}, 32'd2);
        tx_ready = 1'b1;
        stall_left = 10;
        for (int k = 0; k < 20 && stall_seen < 3; k++) tick();
        chk("mid_stalled", stall_seen, 32'd3);
        tx_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("mid_no_write", tx_writes, 32'd0);
        chk("mid_fifo", {29'd0, fifo_count}, 32'd0);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
